seq_playlist_scheduler: RTL and testbench

Scheduler that sits between `command_parser` and `sequence_generator` on the 16-bit config bus. It plays back a host-loaded table of steps: for each step it arms or disarms every generator channel, fires the global GO trigger, dwells a programmed number of cycles, then advances. Host config writes not aimed at the scheduler are forwarded to the generator with priority; scheduler-originated writes fill idle bus cycles.

---
 rtl/seq_playlist_scheduler.sv | 152 +++++++++++++++
 tb/tb_seq_playlist_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_playlist_scheduler.sv
// seq_playlist_scheduler: plays a host-loaded step table onto the generator config bus, forwarding foreign writes first
module seq_playlist_scheduler #(
   parameter int          NUM_CHANNELS         = 4,
   parameter int          NUM_STEPS            = 8,
   parameter logic [15:0] PL_BASE_ADDR         = 16'h0200,
   parameter logic [15:0] SEQ_BASE_ADDR        = 16'h0100,
   parameter logic [15:0] SEQ_CHANNEL_STRIDE   = 16'h0010,
   parameter logic [15:0] SEQ_REG_OFFSET_CTRL  = 16'h000A,
   parameter logic [15:0] SEQ_GLOBAL_CTRL_ADDR = 16'h01F0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] up_addr,
   input  logic [31:0] up_wdata,
   input  logic        up_write,
   output logic [15:0] cfg_addr,
   output logic [31:0] cfg_wdata,
   output logic        cfg_write,
   output logic        busy,
   output logic [3:0]  step_idx,
   output logic        done
);
   typedef enum logic [2:0] {IDLE, ARM, GO, DWELL, NEXT, DISARM, FIN} state_t;
   localparam logic [3:0]  CH_MAX    = 4'(NUM_CHANNELS - 1);
   localparam logic [3:0]  STEP_MAX  = 4'(NUM_STEPS - 1);
   localparam logic [15:0] CH_MASK   = 16'((32'd1 << NUM_CHANNELS) - 32'd1);
   localparam logic [15:0] CLAIM_LEN = 16'(16 + NUM_STEPS);
   state_t state, state_n;
   logic [15:0] off, mask, saddr;
   logic [31:0] sdata;
   logic [3:0]  ch, ch_n, step, step_n, last;
   logic [23:0] dwell, cnt, cnt_n;
   logic        claimed, fwd, ctrl_wr, step_wr, start, stop, loop, load, sreq, done_n;
   logic [15:0] tmask [16];
   logic [23:0] tdwell [16];
   assign off      = up_addr - PL_BASE_ADDR;
   assign claimed  = up_write && up_addr >= PL_BASE_ADDR && off < CLAIM_LEN;
   assign fwd      = up_write && !claimed;
   assign ctrl_wr  = claimed && off == 16'd0;
   assign step_wr  = claimed && off >= 16'd16;
   assign start    = ctrl_wr && up_wdata[0] && !up_wdata[1];
   assign stop     = ctrl_wr && up_wdata[1];
   assign busy     = state != IDLE;
   assign step_idx = step;
   // next-state logic; a scheduler write only advances when the edge is not taken by a forward
   always_comb begin
      state_n = state;
      ch_n    = ch;
      step_n  = step;
      cnt_n   = cnt;
      load    = 1'b0;
      sreq    = 1'b0;
      done_n  = 1'b0;
      saddr   = SEQ_BASE_ADDR + 16'(ch) * SEQ_CHANNEL_STRIDE + SEQ_REG_OFFSET_CTRL;
      sdata   = 32'(mask[ch] && state == ARM);
      case (state)
         IDLE: if (start) begin
            state_n = ARM;
            ch_n    = 4'd0;
            step_n  = 4'd0;
            load    = 1'b1;
         end
         ARM, DISARM: begin
            sreq = 1'b1;
            if (!fwd) begin
               ch_n    = ch == CH_MAX ? 4'd0 : ch + 4'd1;
               state_n = ch != CH_MAX ? state : state == ARM ? GO : FIN;
            end
         end
         GO: begin
            sreq  = 1'b1;
            saddr = SEQ_GLOBAL_CTRL_ADDR;
            sdata = 32'd1;
            if (!fwd) begin
               state_n = DWELL;
               cnt_n   = 24'd0;
            end
         end
         DWELL: begin
            cnt_n   = cnt == dwell ? cnt : cnt + 24'd1;
            state_n = cnt == dwell ? NEXT : DWELL;
         end
         NEXT: begin
            ch_n    = 4'd0;
            step_n  = step < last ? step + 4'd1 : loop ? 4'd0 : step;
            state_n = step < last || loop ? ARM : DISARM;
            load    = step < last || loop;
         end
         FIN: begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      if (stop && state != IDLE) begin
         state_n = DISARM;
         ch_n    = 4'd0;
         step_n  = step;
         sreq    = 1'b0;
         load    = 1'b0;
         done_n  = 1'b0;
      end
   end
   // FSM state and the registered config bus (forwards win the slot)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ch        <= 4'd0;
         step      <= 4'd0;
         cnt       <= 24'd0;
         done      <= 1'b0;
         cfg_write <= 1'b0;
         cfg_addr  <= 16'd0;
         cfg_wdata <= 32'd0;
      end else begin
         state     <= state_n;
         ch        <= ch_n;
         step      <= step_n;
         cnt       <= cnt_n;
         done      <= done_n;
         cfg_write <= fwd || sreq;
         cfg_addr  <= fwd ? up_addr : sreq ? saddr : cfg_addr;
         cfg_wdata <= fwd ? up_wdata : sreq ? sdata : cfg_wdata;
      end
   end
   // step table, playlist options, and the per-step mask/dwell snapshot taken when a step loads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loop  <= 1'b0;
         last  <= 4'd0;
         mask  <= 16'd0;
         dwell <= 24'd0;
         for (int i = 0; i < 16; i++) begin
            tmask[i]  <= 16'd0;
            tdwell[i] <= 24'd0;
         end
      end else begin
         if (start && state == IDLE) begin
            loop <= up_wdata[2];
            last <= up_wdata[11:8] > STEP_MAX ? STEP_MAX : up_wdata[11:8];
         end
         if (load) begin
            mask  <= tmask[step_n];
            dwell <= tdwell[step_n];
         end
         if (step_wr) begin
            tmask[off[3:0]]  <= up_wdata[15:0] & CH_MASK;
            tdwell[off[3:0]] <= up_wdata[31:8];
         end
      end
   end
endmodule

// File: tb/tb_seq_playlist_scheduler.sv
// tb_seq_playlist_scheduler: queue-based reference model plus directed and random stimulus for the playlist scheduler
module tb_seq_playlist_scheduler;
   logic        clk = 1'b0, rst = 1'b1;
   logic [15:0] up_addr = 16'h0;
   logic [31:0] up_wdata = 32'h0;
   logic        up_write = 1'b0;
   logic [15:0] cfg_addr;
   logic [31:0] cfg_wdata;
   logic        cfg_write, busy, done;
   logic [3:0]  step_idx;

   always #5 clk = ~clk;

   seq_playlist_scheduler dut (
      .clk(clk), .rst(rst), .up_addr(up_addr), .up_wdata(up_wdata), .up_write(up_write),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_write(cfg_write),
      .busy(busy), .step_idx(step_idx), .done(done)
   );

   localparam int P_IDLE = 0, P_Q = 1, P_DW = 2, P_NX = 3, P_FIN = 4;
   typedef struct packed {logic [15:0] a; logic [31:0] d;} wr_t;
   typedef struct {logic [15:0] a; logic [31:0] d; int c; int s;} log_t;

   int checks = 0, errors = 0, cyc = 0, done_cyc = -1;
   log_t lg[$];
   wr_t  q[$];
   int   m_phase = P_IDLE, m_step = 0, m_last = 0, m_left = 0, m_dwell = 0, m_after = 0;
   bit   m_loop = 0, m_busy = 0, m_done = 0, exp_w = 0;
   logic [15:0] exp_a = 16'h0;
   logic [31:0] exp_d = 32'h0;
   int   tm[16], td[16];

   logic [15:0] ss_a [9] = '{16'h010A, 16'h011A, 16'h012A, 16'h013A, 16'h01F0, 16'h010A, 16'h011A, 16'h012A, 16'h013A};
   logic [31:0] ss_d [9] = '{32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
   logic [15:0] ct_a [8] = '{16'h010A, 16'h0100, 16'h0100, 16'h0100, 16'h011A, 16'h012A, 16'h013A, 16'h01F0};
   int          lp_s [4] = '{0, 1, 0, 1};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] ctrl_addr(input int ch);
      return 16'(256 + 16 * ch + 10);
   endfunction

   // a step load queues every channel's arm write followed by GO
   task automatic load(input int s);
      m_dwell = td[s];
      for (int i = 0; i < 4; i++) q.push_back('{ctrl_addr(i), 32'((tm[s] >> i) & 1)});
      q.push_back('{16'h01F0, 32'h1});
      m_after = 0;
      m_phase = P_Q;
   endtask

   task automatic disarm();
      q.delete();
      for (int i = 0; i < 4; i++) q.push_back('{ctrl_addr(i), 32'h0});
      m_after = 1;
      m_phase = P_Q;
   endtask

   task automatic model_edge(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
      int off;
      bit claimed, fwd, ctrl, start, stop;
      wr_t x;
      if (r) begin
         m_phase = P_IDLE; m_step = 0; m_last = 0; m_loop = 0; m_done = 0; m_busy = 0;
         exp_w = 0; exp_a = 16'h0; exp_d = 32'h0;
         q.delete();
         for (int i = 0; i < 16; i++) begin tm[i] = 0; td[i] = 0; end
         return;
      end
      off     = int'(a) - 'h200;
      claimed = w && off >= 0 && off < 24;
      fwd     = w && !claimed;
      ctrl    = claimed && off == 0;
      start   = ctrl && d[0];
      stop    = ctrl && d[1];
      exp_w   = 0;
      m_done  = 0;
      if (m_phase == P_IDLE) begin
         if (start && !stop) begin
            m_step = 0;
            m_loop = d[2];
            m_last = (d[11:8] > 4'd7) ? 7 : int'(d[11:8]);
            load(0);
         end
      end else if (stop) disarm();
      else begin
         case (m_phase)
            P_Q: if (!fwd) begin
               x = q.pop_front();
               exp_w = 1; exp_a = x.a; exp_d = x.d;
               if (q.size() == 0) begin
                  if (m_after == 0) begin m_phase = P_DW; m_left = m_dwell + 1; end
                  else m_phase = P_FIN;
               end
            end
            P_DW: begin
               m_left--;
               if (m_left == 0) m_phase = P_NX;
            end
            P_NX: begin
               if (m_step < m_last) begin m_step++; load(m_step); end
               else if (m_loop) begin m_step = 0; load(0); end
               else disarm();
            end
            P_FIN: begin m_done = 1; m_phase = P_IDLE; end
            default: ;
         endcase
      end
      if (fwd) begin exp_w = 1; exp_a = a; exp_d = d; end
      if (claimed && off >= 16) begin tm[off - 16] = int'(d[3:0]); td[off - 16] = int'(d[31:8]); end
      m_busy = m_phase != P_IDLE;
   endtask

   // every edge: advance the model, then compare the DUT just after the edge
   initial forever begin
      @(posedge clk);
      cyc++;
      model_edge(rst, up_write, up_addr, up_wdata);
      #1;
      chk("cfg_write", 64'(cfg_write), 64'(exp_w));
      if (exp_w || rst) begin
         chk("cfg_addr", 64'(cfg_addr), 64'(exp_a));
         chk("cfg_wdata", 64'(cfg_wdata), 64'(exp_d));
      end
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("step_idx", 64'(step_idx), 64'(m_step));
      if (cfg_write) lg.push_back('{cfg_addr, cfg_wdata, cyc, int'(step_idx)});
      if (done) done_cyc = cyc;
   end

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      up_addr = a; up_wdata = d; up_write = 1'b1;
      @(negedge clk);
      up_write = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin @(negedge clk); n++; end
      chk("idle_timeout", 64'(busy), 64'd0);
   endtask

   function automatic int ngo();
      int n = 0;
      foreach (lg[i]) if (lg[i].a == 16'h01F0) n++;
      return n;
   endfunction

   initial begin
      int gi, stop_c, r, n;
      int gs[$];
      repeat (3) @(negedge clk);
      chk("rst_cfg_write", 64'(cfg_write), 64'd0);
      chk("rst_cfg_addr", 64'(cfg_addr), 64'd0);
      chk("rst_cfg_wdata", 64'(cfg_wdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_step_idx", 64'(step_idx), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rst = 1'b0;

      wr(16'h0104, 32'hA5A5A5A5);
      chk("fwd_write", 64'(cfg_write), 64'd1);
      chk("fwd_addr", 64'(cfg_addr), 64'h0104);
      chk("fwd_data", 64'(cfg_wdata), 64'hA5A5A5A5);
      @(negedge clk);
      chk("fwd_one_cycle", 64'(cfg_write), 64'd0);

      lg.delete();
      wr(16'h0210, 32'h0000_0305);
      @(negedge clk);
      chk("claimed_no_fwd", 64'(lg.size()), 64'd0);
      wr(16'h0200, 32'h0000_0001);
      wait_idle(100);
      chk("ss_count", 64'(lg.size()), 64'd9);
      for (int i = 0; i < 9 && i < lg.size(); i++) begin
         chk("ss_addr", 64'(lg[i].a), 64'(ss_a[i]));
         chk("ss_data", 64'(lg[i].d), 64'(ss_d[i]));
      end
      if (lg.size() == 9) begin
         chk("ss_arm_back_to_back", 64'(lg[4].c - lg[0].c), 64'd4);
         chk("ss_dwell_gap", 64'(lg[5].c - lg[4].c), 64'd6);
         chk("ss_done_timing", 64'(done_cyc - lg[8].c), 64'd1);
      end

      wr(16'h0210, 32'h0000_000F);
      lg.delete();
      wr(16'h0200, 32'h0000_0001);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         up_addr = 16'h0100; up_wdata = 32'hC0DE0000 + 32'(i); up_write = 1'b1;
         @(negedge clk);
      end
      up_write = 1'b0;
      wait_idle(100);
      chk("ct_count", 64'(lg.size()), 64'd12);
      for (int i = 0; i < 8 && i < lg.size(); i++) chk("ct_order", 64'(lg[i].a), 64'(ct_a[i]));
      for (int i = 0; i < 3 && i + 1 < lg.size(); i++) chk("ct_fwd_data", 64'(lg[i + 1].d), 64'(32'hC0DE0000 + 32'(i)));

      lg.delete();
      wr(16'h0210, 32'h0000_0101);
      wr(16'h0211, 32'h0000_0102);
      wr(16'h0200, 32'h0000_0105);
      n = 0;
      while (ngo() < 4 && n < 300) begin @(negedge clk); n++; end
      chk("loop_go_timeout", 64'(ngo() >= 4), 64'd1);
      wr(16'h0200, 32'h0000_0002);
      stop_c = cyc;
      wait_idle(100);
      gi = -1;
      foreach (lg[i]) if (lg[i].a == 16'h01F0) begin gs.push_back(lg[i].s); gi = i; end
      chk("loop_go_count", 64'(gs.size()), 64'd4);
      for (int i = 0; i < 4 && i < gs.size(); i++) chk("loop_step_seq", 64'(gs[i]), 64'(lp_s[i]));
      if (lg.size() > 8) begin
         chk("loop_s1_ch0", 64'(lg[5].d), 64'd0);
         chk("loop_s1_ch1", 64'(lg[6].d), 64'd1);
      end
      chk("stop_disarm_count", 64'(lg.size() - gi - 1), 64'd4);
      if (gi >= 0 && gi + 4 < lg.size()) begin
         chk("stop_disarm_addr", 64'(lg[gi + 1].a), 64'h010A);
         chk("stop_disarm_data", 64'(lg[gi + 1].d), 64'd0);
         chk("stop_disarm_next_cycle", 64'(lg[gi + 1].c - stop_c), 64'd1);
         chk("stop_done_timing", 64'(done_cyc - lg[gi + 4].c), 64'd1);
      end

      lg.delete();
      wr(16'h0200, 32'h0000_0003);
      repeat (5) @(negedge clk);
      chk("startstop_idle", 64'(busy), 64'd0);
      chk("startstop_no_write", 64'(lg.size()), 64'd0);

      wr(16'h0210, 32'h0000_000F);
      wr(16'h0200, 32'h0000_0001);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_arm_active", 64'(cfg_write), 64'd1);
      rst = 1'b1;
      #1;
      chk("arst_cfg_write", 64'(cfg_write), 64'd0);
      chk("arst_cfg_addr", 64'(cfg_addr), 64'd0);
      chk("arst_cfg_wdata", 64'(cfg_wdata), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_step_idx", 64'(step_idx), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      lg.delete();
      repeat (10) @(negedge clk);
      chk("post_rst_quiet", 64'(lg.size()), 64'd0);

      for (int k = 0; k < 2500; k++) begin
         @(negedge clk);
         up_write = 1'b0;
         r = $urandom_range(0, 99);
         if (r < 25) begin
            up_write = 1'b1;
            up_wdata = $urandom;
            case ($urandom_range(0, 3))
               0: up_addr = 16'h0100 + 16'($urandom_range(0, 63));
               1: up_addr = 16'h01F0;
               2: up_addr = 16'h0218;
               default: up_addr = 16'($urandom);
            endcase
         end else if (r < 33) begin
            up_write = 1'b1;
            up_addr  = 16'h0210 + 16'($urandom_range(0, 7));
            up_wdata = {24'($urandom_range(0, 4)), 8'($urandom)};
         end else if (r < 36) begin
            up_write = 1'b1;
            up_addr  = 16'h0200;
            up_wdata = {20'h0, 4'($urandom_range(0, 15)), 5'h0, 1'($urandom_range(0, 1)), 2'b01};
         end else if (r < 37) begin
            up_write = 1'b1;
            up_addr  = 16'h0200 + 16'($urandom_range(1, 15));
            up_wdata = $urandom;
         end else if (r == 99 && $urandom_range(0, 3) == 0) begin
            up_write = 1'b1;
            up_addr  = 16'h0200;
            up_wdata = 32'h0000_0002;
         end
      end
      @(negedge clk);
      up_write = 1'b0;
      wr(16'h0200, 32'h0000_0002);
      wait_idle(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
